// File: rtl/cycle_trace_monitor.sv
// rtl/cycle_trace_monitor.sv - run-control and cycle-stamped circular trace buffer; optional CHANGE_ONLY_EN
module cycle_trace_monitor #(
    parameter int NUM_CH     = 6,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 8,
    parameter int MAX_CYCLES = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [NUM_CH*DATA_W-1:0]   watch_data,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [NUM_CH*DATA_W-1:0]   rd_data,
    output logic [CNT_W-1:0]           rd_cycle,
    output logic                       rd_valid,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           cycle_cnt,
    output logic [$clog2(DEPTH):0]     entries,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = NUM_CH * DATA_W;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_CYCLES < 1 || MAX_CYCLES > 2**CNT_W - 1) begin : g_param_check
        $error("cycle_trace_monitor: illegal DEPTH or MAX_CYCLES");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [W-1:0]     buf_data [DEPTH];
    logic [CNT_W-1:0] buf_cyc  [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    oldest;
    logic [AW-1:0]    phys;
    logic             rd_hit;
    logic             start_acc;
    logic             last_cap;
    logic             capture;

`ifdef CHANGE_ONLY_EN
    logic [W-1:0] last_sample;

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_sample <= '0;
        else if (capture)
            last_sample <= watch_data;
    end
`endif

    always_comb begin
        start_acc = start && (state != S_RUN);
        last_cap  = (state == S_RUN) && (cycle_cnt == CNT_W'(MAX_CYCLES));
`ifdef CHANGE_ONLY_EN
        // entries==0 marks the first RUN cycle, which always captures
        capture   = (state == S_RUN) && ((entries == '0) || (watch_data != last_sample));
`else
        capture   = (state == S_RUN);
`endif
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start)    state_nxt = S_RUN;
            S_RUN:          if (last_cap) state_nxt = S_DONE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            wr_ptr    <= '0;
            entries   <= '0;
            overflow  <= 1'b0;
        end else if (start_acc) begin
            cycle_cnt <= CNT_W'(1);
            wr_ptr    <= '0;
            entries   <= '0;
            overflow  <= 1'b0;
        end else if (state == S_RUN) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (capture) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (entries == (AW+1)'(DEPTH))
                    overflow <= 1'b1;
                else
                    entries  <= entries + (AW+1)'(1);
            end
        end
    end

    // Trace RAM is deliberately left uninitialised; reset only blocks the write
    always_ff @(posedge clk) begin
        if (rst_n && capture) begin
            buf_data[wr_ptr] <= watch_data;
            buf_cyc[wr_ptr]  <= cycle_cnt;
        end
    end

    assign oldest = overflow ? wr_ptr : '0;
    assign phys   = oldest + rd_addr;
    assign rd_hit = ({1'b0, rd_addr} < entries);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_cycle <= '0;
        end else if (rd_en) begin
            rd_valid <= rd_hit;
            rd_data  <= rd_hit ? buf_data[phys] : '0;
            rd_cycle <= rd_hit ? buf_cyc[phys]  : '0;
        end else begin
            rd_valid <= 1'b0;
        end
    end
endmodule
